// File: rtl/apb_master_sequencer.sv
// APB master for the codec register file. Two requesters (0 = host, 1 = self-test)
// are arbitrated round-robin. Each accepted command becomes one SETUP/ACCESS transfer,
// and the winner receives a one-cycle completion pulse carrying the read data.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no transfer in flight; APB select low; a new command may be accepted
// SETUP  | PSEL=1, PENABLE=0; command fields are on the bus
// ACCESS | PSEL=1, PENABLE=1; PRDATA is captured at the closing edge, and the
//        | next command may be accepted so that PSEL stays high back-to-back
module apb_master_sequencer #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic                       req0_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] req0_addr,
    input  logic [AMBA_WORD-1:0]       req0_wdata,
    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic                       req1_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] req1_addr,
    input  logic [AMBA_WORD-1:0]       req1_wdata,
    output logic                       rsp_valid,
    output logic                       rsp_id,
    output logic                       rsp_write,
    output logic [AMBA_WORD-1:0]       rsp_rdata,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic [AMBA_WORD-1:0]       PRDATA,
    output logic                       busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                     r_state;
    logic                       r_last_grant;
    logic                       r_id;
    logic                       r_psel;
    logic                       r_penable;
    logic                       r_pwrite;
    logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
    logic [AMBA_WORD-1:0]       r_pwdata;
    logic                       r_rsp_valid;
    logic                       r_rsp_id;
    logic                       r_rsp_write;
    logic [AMBA_WORD-1:0]       r_rsp_rdata;
    logic                       r_busy;

    logic                       w_accept;
    logic                       w_grant;
    logic                       w_hs;
    logic                       w_sel_write;
    logic [AMBA_ADDR_WIDTH-1:0] w_sel_addr;
    logic [AMBA_WORD-1:0]       w_sel_wdata;

    // Round-robin grant and command select; only meaningful inside the accept window
    always_comb begin
        w_accept = (r_state == S_IDLE) || (r_state == S_ACCESS);
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = req1_valid;
        end
        w_hs        = w_accept && (req0_valid || req1_valid);
        w_sel_write = w_grant ? req1_write : req0_write;
        w_sel_addr  = w_grant ? req1_addr  : req0_addr;
        w_sel_wdata = w_grant ? req1_wdata : req0_wdata;
    end

    assign req0_ready = w_accept && req0_valid && !w_grant;
    assign req1_ready = w_accept && req1_valid &&  w_grant;

    // Transfer sequencer: state, registered APB drive and completion response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_write  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_id;
                    r_rsp_write <= r_pwrite;
                    r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
            // A handshake overrides the return to IDLE so back-to-back commands keep PSEL high
            if (w_hs) begin
                r_state      <= S_SETUP;
                r_psel       <= 1'b1;
                r_penable    <= 1'b0;
                r_busy       <= 1'b1;
                r_pwrite     <= w_sel_write;
                r_paddr      <= w_sel_addr;
                r_pwdata     <= w_sel_wdata;
                r_id         <= w_grant;
                r_last_grant <= w_grant;
            end
        end
    end

    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_apb_master_sequencer.sv
// Bench for apb_master_sequencer: queued requesters, a small register-file slave,
// a cycle-scheduled reference model and a response scoreboard.
module tb_apb_master_sequencer;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int NSLOT = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req0_valid, req0_ready, req0_write;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_write;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp_valid, rsp_id, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] PADDR;
    logic          PSEL, PENABLE, PWRITE;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          busy;

    apb_master_sequencer #(.AMBA_WORD(DW), .AMBA_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .busy(busy)
    );

    // Codec register-file slave: CTRL=0x0, DATA_IN=0x4, CODEWORD_WIDTH=0x8, NOISE=0xC
    logic [DW-1:0] slv [0:3];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) slv[i] <= '0;
        end else if (PSEL && PENABLE && PWRITE) begin
            slv[PADDR[3:2]] <= PWDATA;
        end
    end
    assign PRDATA = slv[PADDR[3:2]];

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct {
        int            due;
        logic          id;
        logic          write;
        logic [DW-1:0] rdata;
    } rsp_t;

    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   n_hs = 0;
    cmd_t cq0[$];
    cmd_t cq1[$];
    rsp_t exp_q[$];
    bit   v0 = 1'b0;
    bit   v1 = 1'b0;

    // Reference model: transfers are serial, each occupies the two cycles after its
    // handshake, and the next command can be taken two cycles after the previous one.
    logic [DW-1:0] model_mem [0:3];
    logic          model_last;
    int            next_free;
    int            exp_phase [NSLOT];
    cmd_t          exp_cmd   [NSLOT];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.write = 1'($urandom_range(0, 1));
        c.addr  = AW'($urandom_range(0, 3) * 4);
        c.wdata = $urandom;
        return c;
    endfunction

    function automatic cmd_t mk_cmd(logic w, logic [AW-1:0] a, logic [DW-1:0] d);
        cmd_t c;
        c.write = w;
        c.addr  = a;
        c.wdata = d;
        return c;
    endfunction

    // Scoreboard monitor: every completion pulse is matched to the oldest expected response
    always @(negedge clk) begin
        rsp_t e;
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            n_assert++;
            n_fail++;
            $display("FAIL rsp_missing: no rsp_valid at cycle %0d, expected id=%0d", e.due, e.id);
        end
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d, expected none (cycle %0d)", rsp_id, cyc);
            end else begin
                e = exp_q.pop_front();
                check("rsp_cycle", 64'(cyc), 64'(e.due));
                check("rsp_id", rsp_id, e.id);
                check("rsp_write", rsp_write, e.write);
                check("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    end

    task automatic drive();
        cmd_t c;
        req0_valid = v0;
        if (v0) begin
            c = cq0[0];
            req0_write = c.write; req0_addr = c.addr; req0_wdata = c.wdata;
        end
        req1_valid = v1;
        if (v1) begin
            c = cq1[0];
            req1_write = c.write; req1_addr = c.addr; req1_wdata = c.wdata;
        end
    endtask

    task automatic model_step(input bit chk_ready);
        int    idx;
        logic  g;
        bit    er0, er1;
        cmd_t  c;
        rsp_t  r;
        idx = cyc % NSLOT;
        check("psel", PSEL, exp_phase[idx] != 0);
        check("penable", PENABLE, exp_phase[idx] == 2);
        check("busy", busy, exp_phase[idx] != 0);
        if (exp_phase[idx] != 0) begin
            check("paddr", PADDR, exp_cmd[idx].addr);
            check("pwrite", PWRITE, exp_cmd[idx].write);
            check("pwdata", PWDATA, exp_cmd[idx].wdata);
        end
        exp_phase[idx] = 0;
        if (chk_ready) begin
            g   = (v0 && v1) ? ~model_last : v1;
            er0 = (cyc >= next_free) && v0 && !g;
            er1 = (cyc >= next_free) && v1 && g;
            check("req0_ready", req0_ready, er0);
            check("req1_ready", req1_ready, er1);
            if (er0 || er1) begin
                if (g) begin c = cq1.pop_front(); v1 = 1'b0; end
                else   begin c = cq0.pop_front(); v0 = 1'b0; end
                model_last = g;
                next_free  = cyc + 2;
                exp_phase[(cyc + 1) % NSLOT] = 1;
                exp_phase[(cyc + 2) % NSLOT] = 2;
                exp_cmd[(cyc + 1) % NSLOT]   = c;
                exp_cmd[(cyc + 2) % NSLOT]   = c;
                r.due = cyc + 3;
                r.id  = g;
                r.write = c.write;
                if (c.write) begin
                    model_mem[c.addr[3:2]] = c.wdata;
                    r.rdata = '0;
                end else begin
                    r.rdata = model_mem[c.addr[3:2]];
                end
                exp_q.push_back(r);
                n_hs++;
            end
        end
    endtask

    // One cycle: called just after a rising edge, returns just after the next one
    task automatic tick(input bit t0, input bit t1, input bit p0);
        bit pulsed;
        pulsed = 1'b0;
        if (p0 && !v0) begin
            cq0.push_front(rand_cmd());
            v0 = 1'b1;
            pulsed = 1'b1;
        end
        if (!v0 && t0 && cq0.size() > 0) v0 = 1'b1;
        if (!v1 && t1 && cq1.size() > 0) v1 = 1'b1;
        drive();
        @(negedge clk);
        model_step(1'b1);
        if (pulsed && v0) begin
            void'(cq0.pop_front());
            v0 = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        drive();
        @(negedge clk);
        model_step(1'b0);
        @(posedge clk);
        #1;
        exp_q.delete();
        for (int i = 0; i < NSLOT; i++) exp_phase[i] = 0;
        for (int i = 0; i < 4; i++) model_mem[i] = '0;
        next_free  = 0;
        model_last = 1'b1;
        check("rst_psel", PSEL, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_pwrite", PWRITE, 1'b0);
        check("rst_paddr", PADDR, '0);
        check("rst_pwdata", PWDATA, '0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_write", rsp_write, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, '0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
    endtask

    task automatic run_until_hs(input bit t0, input bit t1);
        int start;
        start = n_hs;
        for (int k = 0; k < 50 && n_hs == start; k++) tick(t0, t1, 1'b0);
        if (n_hs == start) begin
            n_assert++;
            n_fail++;
            $display("FAIL handshake_timeout: got no handshake, expected one within 50 cycles");
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((cq0.size() > 0 || cq1.size() > 0 || exp_q.size() > 0 || v0 || v1) && k < budget) begin
            tick(1'b1, 1'b1, 1'b0);
            k++;
        end
        n_assert++;
        if (cq0.size() > 0 || cq1.size() > 0 || exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d/%0d/%0d outstanding, expected 0", cq0.size(), cq1.size(), exp_q.size());
        end
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        model_last = 1'b1;
        next_free  = 0;
        do_reset();

        // Directed: single write from host
        cq0.push_back(mk_cmd(1'b1, 20'h0, 32'h5));
        drain(40);

        // Directed: host writes DATA_IN, self-test reads it back
        cq0.push_back(mk_cmd(1'b1, 20'h4, 32'hA5A5_0001));
        drain(40);
        cq1.push_back(mk_cmd(1'b0, 20'h4, 32'h0));
        drain(40);

        // Both requesters saturated: alternating grants, back-to-back transfers
        for (int i = 0; i < 4; i++) begin
            cq0.push_back(rand_cmd());
            cq1.push_back(rand_cmd());
        end
        drain(60);

        // Reset during ACCESS of a host write aborts it; host wins first tie afterwards
        cq0.push_back(mk_cmd(1'b1, 20'hC, 32'hDEAD_BEEF));
        run_until_hs(1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        do_reset();
        tick(1'b0, 1'b0, 1'b0);
        cq0.push_back(rand_cmd());
        cq1.push_back(rand_cmd());
        drain(40);

        // CODEWORD_WIDTH write lands at the ACCESS closing edge, then reads back
        cq0.push_back(mk_cmd(1'b1, 20'h8, 32'h3));
        run_until_hs(1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("cw_before_access_edge", slv[2], 32'h0);
        tick(1'b0, 1'b0, 1'b0);
        check("cw_after_access_edge", slv[2], 32'h3);
        cq1.push_back(mk_cmd(1'b0, 20'h8, 32'h0));
        drain(40);

        // One-cycle host valid pulse during SETUP is ignored
        cq0.push_back(mk_cmd(1'b1, 20'h0, 32'h77));
        run_until_hs(1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (cq0.size() < 2 && $urandom_range(0, 2) == 0) cq0.push_back(rand_cmd());
            if (cq1.size() < 2 && $urandom_range(0, 2) == 0) cq1.push_back(rand_cmd());
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
